vcfg_unit: RTL

VCFG_UNIT -- requirements
Module: vcfg_unit

---
 rtl/vcfg_unit.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/vcfg_unit.sv
`default_nettype none
// ============================================================================
// Module   : vcfg_unit
// Purpose  : Vector configuration unit. Decodes vsetvli / vsetivli / vsetvl,
//            computes the new vtype and vl, holds them as architectural state
//            and returns the new vl through a valid/ready response channel.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   req_valid_i/req_ready_o  request handshake (ready only in IDLE)
//   req_instr_i              raw 32-bit configuration instruction
//   req_rs1_i, req_rs2_i     scalar operand values
//   resp_valid_o/resp_ready_i response handshake
//   resp_rd_o, resp_we_o     destination register and its write enable
//   resp_result_o            new vl, zero-extended to 64 bits
//   resp_illegal_o           instruction was not a configuration op
//   flush_i                  abort a request that is still in CALC
//   vtype_o                  {vill, vlut_pack, vlut[2:0], vma, vta, vsew, vlmul}
//   vl_o                     current vector length
// ============================================================================
module vcfg_unit #(
    parameter int unsigned VLEN = 4096,
    parameter int unsigned ELEN = 64
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [31:0]             req_instr_i,
    input  logic [63:0]             req_rs1_i,
    input  logic [63:0]             req_rs2_i,
    output logic                    resp_valid_o,
    input  logic                    resp_ready_i,
    output logic [4:0]              resp_rd_o,
    output logic                    resp_we_o,
    output logic [63:0]             resp_result_o,
    output logic                    resp_illegal_o,
    input  logic                    flush_i,
    output logic [12:0]             vtype_o,
    output logic [$clog2(VLEN):0]   vl_o
);

    localparam int unsigned VL_W       = $clog2(VLEN) + 1;
    localparam logic [12:0] VTYPE_VILL = 13'h1000;
    localparam logic [6:0]  OPC_V      = 7'b1010111;
    localparam logic [2:0]  F3_OPCFG   = 3'b111;
    localparam logic [2:0]  LMUL_RSVD  = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        instr_q;
    logic [63:0]        rs1_q;
    logic [63:0]        rs2_q;
    logic [12:0]        vtype_q;
    logic [VL_W-1:0]    vl_q;
    logic [4:0]         resp_rd_q;
    logic               resp_we_q;
    logic [63:0]        resp_result_q;
    logic               resp_illegal_q;

    logic               w_fire_req;
    logic               w_calc_done;

    // ------------------------------------------------------------------
    // Decode of the captured instruction
    // ------------------------------------------------------------------
    logic               w_cfg_op;
    logic               w_is_vli;
    logic               w_is_vili;
    logic               w_is_vl;
    logic               w_illegal;
    logic [4:0]         w_rd;
    logic [4:0]         w_rs1;
    logic [11:0]        w_vt_raw;
    logic [2:0]         w_vlmul;
    logic [2:0]         w_vsew;
    logic [31:0]        w_sew;
    logic [2:0]         w_frac_k;
    logic [31:0]        w_vlen_scaled;
    logic [31:0]        w_vlmax;
    logic [63:0]        w_vlmax64;
    logic [63:0]        w_avl;
    logic [63:0]        w_new_vl;
    logic               w_vill;
    logic [12:0]        w_vtype_new;
    logic [VL_W-1:0]    w_vl_new;
    logic [63:0]        w_result;

    assign w_cfg_op  = (instr_q[6:0] == OPC_V) && (instr_q[14:12] == F3_OPCFG);
    assign w_is_vli  = w_cfg_op && !instr_q[31];
    assign w_is_vili = w_cfg_op && (instr_q[31:30] == 2'b11);
    assign w_is_vl   = w_cfg_op && (instr_q[31:25] == 7'b1000000);
    assign w_illegal = !(w_is_vli || w_is_vili || w_is_vl);
    assign w_rd      = instr_q[11:7];
    assign w_rs1     = instr_q[19:15];

    // Immediate forms cannot express vlut_pack; vsetivli also lacks vlut[2].
    always_comb begin
        w_vt_raw = 12'd0;
        if (w_is_vl) begin
            w_vt_raw = rs2_q[11:0];
        end else if (w_is_vili) begin
            w_vt_raw = {2'b00, instr_q[29:20]};
        end else begin
            w_vt_raw = {1'b0, instr_q[30:20]};
        end
    end

    assign w_vlmul = w_vt_raw[2:0];
    assign w_vsew  = w_vt_raw[5:3];
    assign w_sew   = 32'd8 << w_vsew;

    // Fractional LMUL encodings 101/110/111 mean 1/8, 1/4, 1/2.
    assign w_frac_k = 3'd4 - {1'b0, w_vlmul[1:0]};

    always_comb begin
        w_vill = 1'b0;
        if (w_vlmul == LMUL_RSVD) begin
            w_vill = 1'b1;
        end
        if (w_sew > ELEN) begin
            w_vill = 1'b1;
        end
        // SEW > ELEN/2^k rewritten as SEW*2^k > ELEN to stay in shifts.
        if (w_vlmul[2] && ((w_sew << w_frac_k) > ELEN)) begin
            w_vill = 1'b1;
        end
        // rs2[63] (vill request) and any reserved upper vtype bit.
        if (w_is_vl && (|rs2_q[63:12])) begin
            w_vill = 1'b1;
        end
    end

    // VLMAX = VLEN * LMUL / SEW; SEW = 8 << vsew so the divide is a shift.
    assign w_vlen_scaled = w_vlmul[2] ? (32'(VLEN) >> w_frac_k)
                                      : (32'(VLEN) << w_vlmul[1:0]);
    assign w_vlmax   = w_vlen_scaled >> ({1'b0, w_vsew} + 4'd3);
    assign w_vlmax64 = {32'd0, w_vlmax};

    always_comb begin
        w_avl = 64'd0;
        if (w_is_vili) begin
            w_avl = {59'd0, w_rs1};
        end else if (w_rs1 != 5'd0) begin
            w_avl = rs1_q;
        end else if (w_rd != 5'd0) begin
            w_avl = w_vlmax64;
        end else begin
            w_avl = {{(64-VL_W){1'b0}}, vl_q};
        end
    end

    // Full-width compare so a huge AVL never aliases to a small vl.
    assign w_new_vl    = (w_avl < w_vlmax64) ? w_avl : w_vlmax64;
    assign w_vtype_new = w_vill ? VTYPE_VILL : {1'b0, w_vt_raw};
    assign w_vl_new    = w_vill ? '0 : w_new_vl[VL_W-1:0];
    assign w_result    = w_vill ? 64'd0 : w_new_vl;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    // A flush arriving in IDLE blocks acceptance for that cycle.
    assign req_ready_o  = (state_q == ST_IDLE) && !flush_i;
    assign resp_valid_o = (state_q == ST_RESP);
    assign w_fire_req   = req_valid_i && req_ready_o;
    assign w_calc_done  = (state_q == ST_CALC) && !flush_i;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (w_fire_req)   state_d = ST_CALC;
            ST_CALC: state_d = flush_i ? ST_IDLE : ST_RESP;
            ST_RESP: if (resp_ready_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            instr_q <= 32'd0;
            rs1_q   <= 64'd0;
            rs2_q   <= 64'd0;
        end else if (w_fire_req) begin
            instr_q <= req_instr_i;
            rs1_q   <= req_rs1_i;
            rs2_q   <= req_rs2_i;
        end
    end

    // Architectural state and response fields update together on the
    // edge entering RESP; illegal ops leave vtype/vl untouched.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vtype_q        <= VTYPE_VILL;
            vl_q           <= '0;
            resp_rd_q      <= 5'd0;
            resp_we_q      <= 1'b0;
            resp_result_q  <= 64'd0;
            resp_illegal_q <= 1'b0;
        end else if (w_calc_done) begin
            resp_rd_q      <= w_rd;
            resp_illegal_q <= w_illegal;
            resp_we_q      <= !w_illegal && (w_rd != 5'd0);
            resp_result_q  <= w_illegal ? 64'd0 : w_result;
            if (!w_illegal) begin
                vtype_q <= w_vtype_new;
                vl_q    <= w_vl_new;
            end
        end
    end

    assign resp_rd_o      = resp_rd_q;
    assign resp_we_o      = resp_we_q;
    assign resp_result_o  = resp_result_q;
    assign resp_illegal_o = resp_illegal_q;
    assign vtype_o        = vtype_q;
    assign vl_o           = vl_q;

endmodule
`default_nettype wire
